z80_page_mapper: RTL and testbench

// - Parametrised Z80 memory paging unit for the board CPLD; successor of the fixed two-port paging logic.
// - Splits the 64K CPU space into 2**WIN_BITS windows, each backed by an I/O-writable page register.
// - Drives the extended address bits plus active-low chip enables for one ROM and NUM_RAM RAM chips.
// - Runs on CLK_24MHz; samples Z80 I/O writes through a synchroniser; memory decode is combinational.

---
 rtl/z80_page_mapper.sv | 183 ++++++++++++++++++
 tb/tb_z80_page_mapper.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_page_mapper.sv
// z80_page_mapper
//   Z80 memory paging unit. The 64K CPU space is split into 2**WIN_BITS
//   windows; each window has an I/O-writable page register that supplies
//   the extended address bits (M_A) and picks which chip is enabled.
//
//   Page register byte: [7:PAGE_BITS] chip field, [PAGE_BITS-1:0] page.
//     chip 0          -> ROM
//     chip 1..NUM_RAM -> RAM_CE[chip-1]
//     higher chips    -> unmapped, no chip enable asserted
//
//   Z80 I/O writes are asynchronous to CLK_24MHz. The write strobe passes
//   through a two-flop synchroniser, and a two-state FSM commits exactly
//   once per strobe. Memory decode is purely combinational.
//
//   Optional feature macro: Z80_MAPPER_READBACK_EN
//     defined   -> IN from a mapper port returns that window's register on D_OUT
//     undefined -> D_OE and D_OUT are tied low and no readback mux is built
//
// Ports
//   CLK_24MHz  in   main clock
//   RES        in   asynchronous reset, active-low
//   IORQ       in   Z80 IORQ, active-low
//   MREQ       in   Z80 MREQ, active-low
//   M1         in   Z80 M1, active-low
//   RD         in   Z80 RD, active-low
//   WR         in   Z80 WR, active-low
//   A          in   Z80 address bus [15:0]
//   D_IN       in   Z80 data bus, input side [7:0]
//   D_OUT      out  readback data [7:0]
//   D_OE       out  readback drive enable, active-high
//   M_A        out  extended memory address [PAGE_BITS-1:0]
//   ROM_CE     out  ROM chip enable, active-low
//   RAM_CE     out  RAM chip enables [NUM_RAM-1:0], active-low
module z80_page_mapper #(
    parameter int         WIN_BITS  = 2,
    parameter int         PAGE_BITS = 5,
    parameter int         NUM_RAM   = 3,
    parameter logic [7:0] PORT_BASE = 8'h10
) (
    input  logic                 CLK_24MHz,
    input  logic                 RES,
    input  logic                 IORQ,
    input  logic                 MREQ,
    input  logic                 M1,
    input  logic                 RD,
    input  logic                 WR,
    input  logic [15:0]          A,
    input  logic [7:0]           D_IN,
    output logic [7:0]           D_OUT,
    output logic                 D_OE,
    output logic [PAGE_BITS-1:0] M_A,
    output logic                 ROM_CE,
    output logic [NUM_RAM-1:0]   RAM_CE
);

    localparam int NUM_WIN = 1 << WIN_BITS;
    localparam int CHIP_W  = 8 - PAGE_BITS;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    // Window 0 boots from ROM page 0; every other window i maps RAM chip 1, page i.
    function automatic logic [7:0] page_rst(input int idx);
        if (idx == 0) return 8'h00;
        return 8'((1 << PAGE_BITS) | idx);
    endfunction

    logic                      wstb_n;
    logic                      s1_q, s1_d;
    logic                      s2_q, s2_d;
    logic [1:0]                vld_q, vld_d;
    logic [7:0]                hold_addr_q, hold_addr_d;
    logic [7:0]                hold_data_q, hold_data_d;
    state_t                    state_q, state_d;
    logic [NUM_WIN-1:0][7:0]   page_q, page_d;

    logic                      hold_match;
    logic [WIN_BITS-1:0]       hold_win;

    assign wstb_n     = IORQ | WR;
    assign hold_match = (hold_addr_q[7:WIN_BITS] == PORT_BASE[7:WIN_BITS]);
    assign hold_win   = hold_addr_q[WIN_BITS-1:0];

    // ------------------------------------------------------------------
    // Synchroniser, hold register and write FSM
    // ------------------------------------------------------------------
    always_comb begin
        s1_d        = wstb_n;
        s2_d        = s1_q;
        // vld marks when s2 holds a real sample of the strobe rather than
        // its reset value. Without it, a strobe already low at reset
        // release would look like a fresh high-to-low edge and commit.
        vld_d       = {vld_q[0], 1'b1};
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        state_d     = state_q;
        page_d      = page_q;

        if (!s1_q) begin
            hold_addr_d = A[7:0];
            hold_data_d = D_IN;
        end

        case (state_q)
            ST_HOLD: begin
                if (s2_q && vld_q[1]) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                // One commit attempt per strobe, then wait for it to rise.
                if (!s2_q) begin
                    if (hold_match) page_d[hold_win] = hold_data_q;
                    state_d = ST_HOLD;
                end
            end
        endcase
    end

    always_ff @(posedge CLK_24MHz or negedge RES) begin
        if (!RES) begin
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            vld_q       <= 2'b00;
            hold_addr_q <= 8'h00;
            hold_data_q <= 8'h00;
            state_q     <= ST_HOLD;
            for (int i = 0; i < NUM_WIN; i++) page_q[i] <= page_rst(i);
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            vld_q       <= vld_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            state_q     <= state_d;
            page_q      <= page_d;
        end
    end

    // ------------------------------------------------------------------
    // Combinational memory decode
    // ------------------------------------------------------------------
    logic [WIN_BITS-1:0] win;
    logic [7:0]          sel;
    logic [CHIP_W-1:0]   chip;
    logic                mem_act;

    assign win     = A[15 -: WIN_BITS];
    assign sel     = page_q[win];
    assign chip    = sel[7:PAGE_BITS];
    assign M_A     = sel[PAGE_BITS-1:0];
    // Refresh cycles have MREQ low with RD and WR high: no chip enabled.
    assign mem_act = !MREQ && (!RD || !WR);
    assign ROM_CE  = !(mem_act && (chip == '0));

    always_comb begin
        RAM_CE = '1;
        for (int k = 0; k < NUM_RAM; k++) begin
            RAM_CE[k] = !(mem_act && (chip == CHIP_W'(k + 1)));
        end
    end

    // Address bits between the window select and the port byte play no part.
    logic unused_addr;
    assign unused_addr = ^A[15-WIN_BITS:8];

    // ------------------------------------------------------------------
    // Optional readback
    // ------------------------------------------------------------------
`ifdef Z80_MAPPER_READBACK_EN
    logic port_hit;
    assign port_hit = (A[7:WIN_BITS] == PORT_BASE[7:WIN_BITS]);
    // M1 high keeps interrupt acknowledge cycles off the data bus.
    assign D_OE  = RES && !IORQ && !RD && M1 && port_hit;
    assign D_OUT = RES ? page_q[A[WIN_BITS-1:0]] : 8'h00;
`else
    logic unused_rb;
    assign unused_rb = M1;
    assign D_OE  = 1'b0;
    assign D_OUT = 8'h00;
`endif

endmodule

// File: tb/tb_z80_page_mapper.sv
module tb_z80_page_mapper;

    logic        clk;
    logic        res;
    logic        iorq, mreq, m1, rd, wr;
    logic [15:0] a;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [4:0]  m_a;
    logic        rom_ce;
    logic [2:0]  ram_ce;

    int checks = 0;
    int errors = 0;

    z80_page_mapper dut (
        .CLK_24MHz (clk),
        .RES       (res),
        .IORQ      (iorq),
        .MREQ      (mreq),
        .M1        (m1),
        .RD        (rd),
        .WR        (wr),
        .A         (a),
        .D_IN      (d_in),
        .D_OUT     (d_out),
        .D_OE      (d_oe),
        .M_A       (m_a),
        .ROM_CE    (rom_ce),
        .RAM_CE    (ram_ce)
    );

    initial clk = 1'b0;
    always #21 clk = ~clk;

    // op: 0 = memory decode check, 1 = OUT write, 2 = IN readback check
    typedef struct {
        int          op;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        mreq, rd, wr;
        logic        rom;
        logic [2:0]  ram;
        logic [4:0]  ma;
        logic        oe;
    } vec_t;

    vec_t vecs[$];

    task automatic add_mem(input logic [15:0] ad, input logic mq, input logic r, input logic w,
                           input logic rom, input logic [2:0] ram, input logic [4:0] ma);
        vec_t v;
        v.op = 0; v.addr = ad; v.data = 8'h00; v.mreq = mq; v.rd = r; v.wr = w;
        v.rom = rom; v.ram = ram; v.ma = ma; v.oe = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic add_out(input logic [15:0] ad, input logic [7:0] dt);
        vec_t v;
        v.op = 1; v.addr = ad; v.data = dt; v.mreq = 1'b1; v.rd = 1'b1; v.wr = 1'b0;
        v.rom = 1'b1; v.ram = 3'b111; v.ma = 5'd0; v.oe = 1'b0;
        vecs.push_back(v);
    endtask

    // data = register value expected on D_OUT when the readback build drives it
    task automatic add_in(input logic [15:0] ad, input logic oe, input logic [7:0] dt);
        vec_t v;
        v.op = 2; v.addr = ad; v.data = dt; v.mreq = 1'b1; v.rd = 1'b0; v.wr = 1'b1;
        v.rom = 1'b1; v.ram = 3'b111; v.ma = 5'd0; v.oe = oe;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic bus_idle();
        iorq = 1'b1; mreq = 1'b1; m1 = 1'b1; rd = 1'b1; wr = 1'b1;
    endtask

    task automatic io_write(input logic [15:0] ad, input logic [7:0] dt);
        @(posedge clk); #1;
        bus_idle();
        a = ad; d_in = dt; iorq = 1'b0; wr = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        iorq = 1'b1; wr = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic mem_chk(input string nm, input vec_t v);
        @(negedge clk);
        bus_idle();
        a = v.addr; mreq = v.mreq; rd = v.rd; wr = v.wr;
        #2;
        chk({nm, "_rom"}, 32'(rom_ce), 32'(v.rom));
        chk({nm, "_ram"}, 32'(ram_ce), 32'(v.ram));
        chk({nm, "_ma"},  32'(m_a),    32'(v.ma));
        chk({nm, "_oe"},  32'(d_oe),   32'd0);
        bus_idle();
    endtask

    task automatic in_chk(input string nm, input vec_t v);
        @(negedge clk);
        bus_idle();
        a = v.addr; iorq = 1'b0; rd = 1'b0;
        #2;
`ifdef Z80_MAPPER_READBACK_EN
        chk({nm, "_oe"}, 32'(d_oe), 32'(v.oe));
        if (v.oe) chk({nm, "_dout"}, 32'(d_out), 32'(v.data));
`else
        chk({nm, "_oe"},   32'(d_oe),  32'd0);
        chk({nm, "_dout"}, 32'(d_out), 32'd0);
`endif
        bus_idle();
    endtask

    initial begin
        // ---------------- vector table ----------------
        add_mem(16'h0000, 0, 0, 1, 1'b0, 3'b111, 5'd0);   // default window 0: ROM page 0
        add_mem(16'h4000, 0, 0, 1, 1'b1, 3'b110, 5'd1);
        add_mem(16'h8000, 0, 0, 1, 1'b1, 3'b110, 5'd2);
        add_mem(16'hC000, 0, 0, 1, 1'b1, 3'b110, 5'd3);
        add_out(16'h0010, 8'h21);
        add_mem(16'h0000, 0, 0, 1, 1'b1, 3'b110, 5'd1);
        add_out(16'h0011, 8'h45);                          // chip 2, page 5
        add_mem(16'h7FFF, 0, 0, 1, 1'b1, 3'b101, 5'd5);
        add_in (16'h0011, 1'b1, 8'h45);
        add_in (16'h0020, 1'b0, 8'h00);                    // not a mapper port
        add_out(16'h0013, 8'hE0);                          // chip 7: unmapped
        add_mem(16'hC000, 0, 0, 1, 1'b1, 3'b111, 5'd0);
        add_out(16'h0020, 8'h00);                          // no match
        add_out(16'h0014, 8'h00);                          // no match (next block)
        add_mem(16'h0000, 0, 0, 1, 1'b1, 3'b110, 5'd1);
        add_mem(16'h4000, 0, 0, 1, 1'b1, 3'b101, 5'd5);
        add_mem(16'h8000, 0, 0, 1, 1'b1, 3'b110, 5'd2);
        add_mem(16'hFFFF, 0, 0, 1, 1'b1, 3'b111, 5'd0);
        add_mem(16'h4000, 0, 1, 1, 1'b1, 3'b111, 5'd5);    // refresh
        add_mem(16'h0000, 1, 0, 1, 1'b1, 3'b111, 5'd1);    // no MREQ
        add_mem(16'h8000, 0, 1, 0, 1'b1, 3'b110, 5'd2);    // memory write
        add_out(16'hAB12, 8'h63);                          // A[15:8] ignored; chip 3 page 3
        add_mem(16'h8000, 0, 0, 1, 1'b1, 3'b011, 5'd3);
        add_in (16'hAB12, 1'b1, 8'h63);
        add_out(16'h0010, 8'h1F);                          // ROM, top page
        add_mem(16'h3FFF, 0, 0, 1, 1'b0, 3'b111, 5'd31);

        // ---------------- reset state ----------------
        bus_idle();
        a = 16'h4000; d_in = 8'h00; res = 1'b0;
        mreq = 1'b0; rd = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rom",  32'(rom_ce), 32'd1);
        chk("rst_ram",  32'(ram_ce), 32'b110);
        chk("rst_ma",   32'(m_a),    32'd1);
        chk("rst_oe",   32'(d_oe),   32'd0);
        chk("rst_dout", 32'(d_out),  32'd0);
        bus_idle();
        @(posedge clk); #1;
        res = 1'b1;
        repeat (4) @(posedge clk);

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            case (vecs[i].op)
                0: mem_chk(nm, vecs[i]);
                1: io_write(vecs[i].addr, vecs[i].data);
                default: in_chk(nm, vecs[i]);
            endcase
        end

        // ---------------- commit latency ----------------
        // Window 2 holds page 3; write 0x2A (chip 1, page 10) via port 0x12
        // with A[15:14] = 2 so M_A shows window 2 throughout.
        @(posedge clk); #1;
        bus_idle();
        a = 16'h8012; d_in = 8'h2A; iorq = 1'b0; wr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("lat_edge2", 32'(m_a), 32'd3);
        @(posedge clk);
        @(negedge clk);
        chk("lat_edge3", 32'(m_a), 32'd10);
        iorq = 1'b1; wr = 1'b1;
        repeat (4) @(posedge clk);

        // ---------------- interrupt acknowledge ----------------
        @(posedge clk); #1;
        a = 16'h0010; d_in = 8'h00; iorq = 1'b0; m1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("inta_oe", 32'(d_oe), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        bus_idle();
        repeat (4) @(posedge clk);
        begin
            vec_t v;
            v.op = 0; v.addr = 16'h0000; v.data = 8'h00; v.mreq = 0; v.rd = 0; v.wr = 1;
            v.rom = 1'b0; v.ram = 3'b111; v.ma = 5'd31; v.oe = 1'b0;
            mem_chk("inta_win0", v);
        end

        // ---------------- reset during a write ----------------
        @(posedge clk); #1;
        bus_idle();
        a = 16'h8012; d_in = 8'h33; iorq = 1'b0; wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        res = 1'b0;
        @(negedge clk);
        chk("rstw_ma", 32'(m_a),  32'd2);
        chk("rstw_oe", 32'(d_oe), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        res = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        iorq = 1'b1; wr = 1'b1;
        repeat (4) @(posedge clk);
        begin
            vec_t v;
            v.op = 0; v.addr = 16'h8000; v.data = 8'h00; v.mreq = 0; v.rd = 0; v.wr = 1;
            v.rom = 1'b1; v.ram = 3'b110; v.ma = 5'd2; v.oe = 1'b0;
            mem_chk("rstw_win2", v);
        end
        begin
            vec_t v;
            v.op = 0; v.addr = 16'h0000; v.data = 8'h00; v.mreq = 0; v.rd = 0; v.wr = 1;
            v.rom = 1'b0; v.ram = 3'b111; v.ma = 5'd0; v.oe = 1'b0;
            mem_chk("rstw_win0", v);
        end

        // A normal write still works after the aborted one.
        io_write(16'h0012, 8'h47);                         // chip 2, page 7
        begin
            vec_t v;
            v.op = 0; v.addr = 16'hBFFF; v.data = 8'h00; v.mreq = 0; v.rd = 0; v.wr = 1;
            v.rom = 1'b1; v.ram = 3'b101; v.ma = 5'd7; v.oe = 1'b0;
            mem_chk("post_rst_wr", v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
